// File: rtl/parity_stream_unit_pkg.sv
// Shared definitions for the parity stream unit: FSM state encodings and
// the output word-count width helper.
package parity_stream_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Width needed to hold a word count from 0 up to max_words inclusive.
    function automatic int cnt_w(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/parity_stream_unit_reduce.sv
// Combinational XOR reduction of one data word to its parity bit.
// Kept as a separate module so other integrity stages can reuse it.
module parity_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    logic [WIDTH-1:0] chain;

    assign chain[0] = data[0];

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : gen_chain
            assign chain[gi] = chain[gi-1] ^ data[gi];
        end
    endgenerate

    assign parity = chain[WIDTH-1];

endmodule

// File: rtl/parity_stream_unit.sv
// Framed parity generator/checker: XOR-accumulates WIDTH-bit words until the
// last beat, then holds parity, error, count and overflow on an output handshake.
module parity_stream_unit
    import parity_stream_unit_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    parameter bit ODD       = 1'b0,
    localparam int CNT_W    = cnt_w(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_check,
    input  logic             in_parity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_error,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_t           state_reg, state_next;
    logic             acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic             check_reg, check_next;

    logic             out_valid_reg, out_valid_next;
    logic             out_parity_reg, out_parity_next;
    logic             out_error_reg, out_error_next;
    logic [CNT_W-1:0] out_count_reg, out_count_next;
    logic             out_overflow_reg, out_overflow_next;

    logic             word_par;
    logic             beat;

    parity_reduce #(.WIDTH(WIDTH)) u_reduce (
        .data   (in_data),
        .parity (word_par)
    );

    assign in_ready = (state_reg != ST_HOLD) || out_ready;
    assign beat     = in_valid && in_ready;

    always_comb begin
        state_next        = state_reg;
        acc_next          = acc_reg;
        cnt_next          = cnt_reg;
        ovf_next          = ovf_reg;
        check_next        = check_reg;
        out_valid_next    = out_valid_reg;
        out_parity_next   = out_parity_reg;
        out_error_next    = out_error_reg;
        out_count_next    = out_count_reg;
        out_overflow_next = out_overflow_reg;

        if (state_reg == ST_HOLD && out_ready) begin
            out_valid_next = 1'b0;
            state_next     = ST_IDLE;
        end

        if (beat) begin
            // Any beat outside ACCUM opens a new frame, including the one
            // that coincides with the output handshake.
            if (state_reg != ST_ACCUM) begin
                acc_next   = word_par;
                cnt_next   = CNT_W'(1);
                ovf_next   = 1'b0;
                check_next = in_check;
            end else begin
                acc_next = acc_reg ^ word_par;
                if (cnt_reg == MAX_CNT) begin
                    ovf_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            if (in_last) begin
                state_next        = ST_HOLD;
                out_valid_next    = 1'b1;
                out_parity_next   = acc_next ^ ODD;
                out_error_next    = check_next & (acc_next ^ ODD ^ in_parity);
                out_count_next    = cnt_next;
                out_overflow_next = ovf_next;
            end else begin
                state_next = ST_ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            acc_reg          <= 1'b0;
            cnt_reg          <= '0;
            ovf_reg          <= 1'b0;
            check_reg        <= 1'b0;
            out_valid_reg    <= 1'b0;
            out_parity_reg   <= 1'b0;
            out_error_reg    <= 1'b0;
            out_count_reg    <= '0;
            out_overflow_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            acc_reg          <= acc_next;
            cnt_reg          <= cnt_next;
            ovf_reg          <= ovf_next;
            check_reg        <= check_next;
            out_valid_reg    <= out_valid_next;
            out_parity_reg   <= out_parity_next;
            out_error_reg    <= out_error_next;
            out_count_reg    <= out_count_next;
            out_overflow_reg <= out_overflow_next;
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_parity   = out_parity_reg;
    assign out_error    = out_error_reg;
    assign out_count    = out_count_reg;
    assign out_overflow = out_overflow_reg;

endmodule

// File: tb/tb_parity_stream_unit.sv
// Scoreboard bench for parity_stream_unit: two builds (8-bit even, 3-bit odd)
// driven with directed and random frames, checked against a frame-level model.
module tb_parity_stream_unit;

    typedef struct {
        bit parity;
        bit error;
        int count;
        bit overflow;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Build A: WIDTH=8, MAX_WORDS=4, even parity
    logic       a_in_valid, a_in_ready, a_in_last, a_in_check, a_in_parity;
    logic [7:0] a_in_data;
    logic       a_out_valid, a_out_ready, a_out_parity, a_out_error, a_out_overflow;
    logic [2:0] a_out_count;

    // Build B: WIDTH=3, MAX_WORDS=16, odd parity
    logic       b_in_valid, b_in_ready, b_in_last, b_in_check, b_in_parity;
    logic [2:0] b_in_data;
    logic       b_out_valid, b_out_ready, b_out_parity, b_out_error, b_out_overflow;
    logic [4:0] b_out_count;

    exp_t       q_a[$];
    exp_t       q_b[$];
    logic [7:0] wq[$];
    int         compared = 0;
    int         mismatched = 0;
    bit         done = 1'b0;
    bit         stop = 1'b0;

    always #5 clk = ~clk;

    parity_stream_unit #(.WIDTH(8), .MAX_WORDS(4), .ODD(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_last(a_in_last), .in_check(a_in_check), .in_parity(a_in_parity),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_parity(a_out_parity),
        .out_error(a_out_error), .out_count(a_out_count), .out_overflow(a_out_overflow)
    );

    parity_stream_unit #(.WIDTH(3), .MAX_WORDS(16), .ODD(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_last(b_in_last), .in_check(b_in_check), .in_parity(b_in_parity),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_parity(b_out_parity),
        .out_error(b_out_error), .out_count(b_out_count), .out_overflow(b_out_overflow)
    );

    // Frame-level reference: parity from total population count of the frame.
    function automatic exp_t model(input logic [7:0] w[$], input int width, input int maxw,
                                   input bit odd, input bit chk, input bit ip);
        int   ones;
        exp_t e;
        logic [7:0] mask;
        ones = 0;
        mask = 8'((1 << width) - 1);
        foreach (w[i]) ones += $countones(w[i] & mask);
        e.parity   = bit'(ones % 2) ^ odd;
        e.count    = (w.size() > maxw) ? maxw : w.size();
        e.overflow = (w.size() > maxw);
        e.error    = chk && (e.parity != ip);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input bit chk, input bit ip, input int max_gap);
        int n;
        bit acc;
        q_a.push_back(model(wq, 8, 4, 1'b0, chk, ip));
        for (int i = 0; i < wq.size(); i++) begin
            a_in_valid  = 1'b1;
            a_in_data   = wq[i];
            a_in_last   = (i == wq.size() - 1);
            a_in_check  = (i == 0) ? chk : 1'($urandom);
            a_in_parity = a_in_last ? ip : 1'($urandom);
            n = 0;
            acc = 1'b0;
            while (!acc) begin
                @(negedge clk);
                acc = a_in_ready;
                tick();
                n++;
                if (!acc && n > 300) begin
                    $display("FAIL a_accept_timeout: in_ready=0 after %0d cycles, need 1", n);
                    $fatal(1, "input stalled");
                end
            end
            a_in_valid = 1'b0;
            a_in_data  = 8'($urandom);
            a_in_last  = 1'($urandom);
            repeat ($urandom_range(0, max_gap)) tick();
        end
    endtask

    task automatic send_b(input bit chk, input bit ip);
        int n;
        bit acc;
        q_b.push_back(model(wq, 3, 16, 1'b1, chk, ip));
        for (int i = 0; i < wq.size(); i++) begin
            b_in_valid  = 1'b1;
            b_in_data   = wq[i][2:0];
            b_in_last   = (i == wq.size() - 1);
            b_in_check  = (i == 0) ? chk : 1'($urandom);
            b_in_parity = b_in_last ? ip : 1'($urandom);
            n = 0;
            acc = 1'b0;
            while (!acc) begin
                @(negedge clk);
                acc = b_in_ready;
                tick();
                n++;
                if (!acc && n > 300) begin
                    $display("FAIL b_accept_timeout: in_ready=0 after %0d cycles, need 1", n);
                    $fatal(1, "input stalled");
                end
            end
            b_in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && (q_a.size() != 0 || q_b.size() != 0); n++) tick();
    endtask

    task automatic check_result(input string tag, input exp_t e, input bit p, input bit er,
                                input int c, input bit o);
        compared++;
        if (p !== e.parity || er !== e.error || c != e.count || o !== e.overflow) begin
            mismatched++;
            $display("FAIL %s_result: got par=%0b err=%0b cnt=%0d ovf=%0b, need par=%0b err=%0b cnt=%0d ovf=%0b",
                     tag, p, er, c, o, e.parity, e.error, e.count, e.overflow);
        end
    endtask

    // Monitor: compares every cycle an output is presented, pops on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            compared++;
            if ({a_out_valid, a_out_parity, a_out_error, a_out_count, a_out_overflow} !== 7'd0 ||
                a_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL reset_state: a_valid=%0b a_cnt=%0d a_rdy=%0b b_valid=%0b b_rdy=%0b, need 0 0 1 0 1",
                         a_out_valid, a_out_count, a_in_ready, b_out_valid, b_in_ready);
            end
        end else begin
            compared++;
            if (a_in_ready !== (!a_out_valid || a_out_ready)) begin
                mismatched++;
                $display("FAIL a_in_ready: got %0b, need %0b", a_in_ready, (!a_out_valid || a_out_ready));
            end
            if (a_out_valid) begin
                if (q_a.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL a_unexpected_valid: got out_valid=1, need 0 (no frame pending)");
                end else begin
                    check_result("a", q_a[0], a_out_parity, a_out_error, int'(a_out_count), a_out_overflow);
                    if (a_out_ready) begin
                        $display("[a] frame par=%0b err=%0b cnt=%0d ovf=%0b", a_out_parity, a_out_error,
                                 a_out_count, a_out_overflow);
                        void'(q_a.pop_front());
                    end
                end
            end
            if (b_out_valid) begin
                if (q_b.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL b_unexpected_valid: got out_valid=1, need 0 (no frame pending)");
                end else begin
                    check_result("b", q_b[0], b_out_parity, b_out_error, int'(b_out_count), b_out_overflow);
                    if (b_out_ready) begin
                        $display("[b] frame par=%0b err=%0b cnt=%0d ovf=%0b", b_out_parity, b_out_error,
                                 b_out_count, b_out_overflow);
                        void'(q_b.pop_front());
                    end
                end
            end
        end
        if (done) begin
            compared++;
            if (q_a.size() != 0 || q_b.size() != 0) begin
                mismatched++;
                $display("FAIL drain: pending a=%0d b=%0d, need 0 0", q_a.size(), q_b.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $finish;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "timeout");
    end

    initial begin
        a_in_valid = 0; a_in_data = 0; a_in_last = 0; a_in_check = 0; a_in_parity = 0;
        b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_in_check = 0; b_in_parity = 0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Legacy 3-input truth table on build B (odd parity inverts it)
        for (int v = 0; v < 8; v++) begin
            wq.delete();
            wq.push_back(8'(v));
            send_b(1'b0, 1'b0);
        end
        // Random multi-beat frames on build B, some longer than MAX_WORDS
        for (int f = 0; f < 12; f++) begin
            wq.delete();
            for (int i = 0; i < $urandom_range(1, 20); i++) wq.push_back(8'($urandom));
            send_b(1'($urandom), 1'($urandom));
        end
        drain();

        // Directed frames on build A
        wq.delete(); wq.push_back(8'hFF); wq.push_back(8'h01); wq.push_back(8'h03);
        send_a(1'b0, 1'b0, 1);
        wq.delete(); wq.push_back(8'h0F);
        send_a(1'b1, 1'b1, 0);
        send_a(1'b1, 1'b0, 0);
        wq.delete();
        for (int i = 0; i < 6; i++) wq.push_back(8'h01);
        send_a(1'b0, 1'b0, 0);
        drain();

        // Held result with back-pressure, next frame waiting on the input
        a_out_ready = 1'b0;
        wq.delete(); wq.push_back(8'h3C);
        send_a(1'b0, 1'b0, 0);
        wq.delete(); wq.push_back(8'h01);
        fork
            send_a(1'b1, 1'b0, 0);
            begin
                repeat (6) tick();
                a_out_ready = 1'b1;
            end
        join
        drain();

        // Reset while a result is held: it must vanish
        a_out_ready = 1'b0;
        wq.delete(); wq.push_back(8'h77);
        send_a(1'b0, 1'b0, 0);
        repeat (3) tick();
        rst_n = 1'b0;
        q_a.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        tick();

        // Reset two beats into a frame, then a fresh single-beat frame
        a_in_valid = 1'b1; a_in_last = 1'b0; a_in_data = 8'hAA;
        tick();
        a_in_data = 8'h55;
        tick();
        rst_n = 1'b0;
        a_in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        wq.delete(); wq.push_back(8'h01);
        send_a(1'b0, 1'b0, 0);
        drain();

        // Random frames with random output back-pressure
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    wq.delete();
                    for (int i = 0; i < $urandom_range(1, 6); i++) wq.push_back(8'($urandom));
                    send_a(1'($urandom), 1'($urandom), 2);
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    tick();
                    a_out_ready = ($urandom_range(0, 3) != 0);
                end
                a_out_ready = 1'b1;
            end
        join
        drain();
        repeat (2) tick();
        done = 1'b1;
    end

endmodule
